nco_sweep_ctrl: RTL and testbench

Sequencer that drives the NCO frequency-control input (`delta_index_i` / `valid_i` of the NCO top) with a programmable stepped frequency sweep. Latches a start frequency, step size, step count and per-step dwell on a start pulse. Emits a registered per-cycle phase increment, either as a one-shot ramp or as a continuous triangle sweep. Sits between the configuration/register layer and the NCO, and owns all timing of frequency changes.

---
 rtl/nco_sweep_ctrl.sv | 124 ++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - stepped frequency sweep sequencer feeding the NCO phase increment
module nco_sweep_ctrl #(
  parameter int NSTEP_W = 16,
  parameter int DWELL_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic                      hold_i,
  input  logic                      mode_i,
  input  logic signed [31:0]        f_start_i,
  input  logic signed [31:0]        f_step_i,
  input  logic        [NSTEP_W-1:0] num_steps_i,
  input  logic        [DWELL_W-1:0] dwell_i,
  output logic signed [31:0]        delta_index_o,
  output logic                      valid_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic        [NSTEP_W-1:0] step_idx_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  localparam logic [NSTEP_W-1:0] STEP_ONE  = NSTEP_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  state_t              state;
  logic                mode_q;
  logic signed [31:0]  f_step_q;
  logic [NSTEP_W-1:0]  num_steps_q;
  logic [DWELL_W-1:0]  dwell_q;
  logic [DWELL_W-1:0]  dwell_cnt;

  // Sweep FSM: latches config on start, walks position/delta per dwell, all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mode_q        <= 1'b0;
      f_step_q      <= '0;
      num_steps_q   <= '0;
      dwell_q       <= '0;
      dwell_cnt     <= '0;
      delta_index_o <= '0;
      valid_o       <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      step_idx_o    <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          valid_o       <= 1'b0;
          busy_o        <= 1'b0;
          delta_index_o <= '0;
          step_idx_o    <= '0;
          if (start_i && !abort_i) begin
            mode_q        <= mode_i;
            f_step_q      <= f_step_i;
            num_steps_q   <= num_steps_i;
            dwell_q       <= dwell_i;
            dwell_cnt     <= '0;
            delta_index_o <= f_start_i;
            step_idx_o    <= '0;
            valid_o       <= 1'b1;
            busy_o        <= 1'b1;
            state         <= UP;
          end
        end
        UP, DOWN: begin
          if (abort_i) begin
            state         <= IDLE;
            valid_o       <= 1'b0;
            busy_o        <= 1'b0;
            delta_index_o <= '0;
            step_idx_o    <= '0;
            dwell_cnt     <= '0;
          end else if (hold_i) begin
            // frozen: counters and frequency keep their values
          end else if (dwell_cnt < dwell_q) begin
            dwell_cnt <= dwell_cnt + DWELL_ONE;
          end else begin
            dwell_cnt <= '0;
            if (state == UP) begin
              if (step_idx_o < num_steps_q) begin
                step_idx_o    <= step_idx_o + STEP_ONE;
                delta_index_o <= delta_index_o + f_step_q;
              end else if (!mode_q) begin
                state         <= IDLE;
                done_o        <= 1'b1;
                valid_o       <= 1'b0;
                busy_o        <= 1'b0;
                delta_index_o <= '0;
                step_idx_o    <= '0;
              end else if (num_steps_q != '0) begin
                state         <= DOWN;
                step_idx_o    <= step_idx_o - STEP_ONE;
                delta_index_o <= delta_index_o - f_step_q;
              end
              // triangle with zero steps stays at f_start indefinitely
            end else begin
              if (step_idx_o != '0) begin
                step_idx_o    <= step_idx_o - STEP_ONE;
                delta_index_o <= delta_index_o - f_step_q;
              end else begin
                state         <= UP;
                step_idx_o    <= step_idx_o + STEP_ONE;
                delta_index_o <= delta_index_o + f_step_q;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb/tb_nco_sweep_ctrl.sv - self-checking bench for nco_sweep_ctrl
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        hold = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] f_start = '0;
  logic [31:0] f_step = '0;
  logic [15:0] num_steps = '0;
  logic [15:0] dwell = '0;
  logic [31:0] delta;
  logic        valid;
  logic        busy;
  logic        done;
  logic [15:0] idx;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  nco_sweep_ctrl #(.NSTEP_W(16), .DWELL_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .abort_i       (abort),
    .hold_i        (hold),
    .mode_i        (mode),
    .f_start_i     (f_start),
    .f_step_i      (f_step),
    .num_steps_i   (num_steps),
    .dwell_i       (dwell),
    .delta_index_o (delta),
    .valid_o       (valid),
    .busy_o        (busy),
    .done_o        (done),
    .step_idx_o    (idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sweep position derived in closed form from the count of unheld cycles
  logic        m_act = 1'b0;
  logic        m_mode = 1'b0;
  logic [31:0] m_fs = '0;
  logic [31:0] m_step = '0;
  int          m_n = 0;
  int          m_d = 0;
  longint      m_k = 0;
  longint      mj;
  int          mp;
  int          mpos;
  logic [31:0] e_delta = '0;
  logic        e_valid = 1'b0;
  logic        e_busy = 1'b0;
  logic        e_done = 1'b0;
  logic [15:0] e_idx = '0;

  // Model update, one step per clock using the inputs the DUT samples on the same edge
  always @(posedge clk) begin
    if (rst) begin
      m_act = 1'b0;
      e_delta = '0; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_idx = '0;
    end else if (!m_act) begin
      e_done = 1'b0;
      if (start && !abort) begin
        m_mode = mode; m_fs = f_start; m_step = f_step;
        m_n = int'(num_steps); m_d = int'(dwell); m_k = 0; m_act = 1'b1;
        e_delta = f_start; e_valid = 1'b1; e_busy = 1'b1; e_idx = '0;
      end
    end else if (abort) begin
      m_act = 1'b0;
      e_delta = '0; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_idx = '0;
    end else if (!hold) begin
      m_k = m_k + 1;
      mj = m_k / longint'(m_d + 1);
      if (!m_mode && mj > longint'(m_n)) begin
        m_act = 1'b0;
        e_delta = '0; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b1; e_idx = '0;
      end else begin
        if (!m_mode) mpos = int'(mj);
        else if (m_n == 0) mpos = 0;
        else begin
          mp = int'(mj % longint'(2 * m_n));
          mpos = (mp <= m_n) ? mp : 2 * m_n - mp;
        end
        e_idx = 16'(mpos);
        e_delta = m_fs + 32'(mpos) * m_step;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_delta", delta, e_delta);
      check("cmp_valid", 32'(valid), 32'(e_valid));
      check("cmp_busy", 32'(busy), 32'(e_busy));
      check("cmp_done", 32'(done), 32'(e_done));
      check("cmp_idx", 32'(idx), 32'(e_idx));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic launch(input logic md, input logic [31:0] fs, input logic [31:0] st,
                        input logic [15:0] n, input logic [15:0] d);
    mode = md; f_start = fs; f_step = st; num_steps = n; dwell = d;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp1 [4];
    logic [31:0] exp2 [9];
    int n011;
    int done_at;
    exp1 = '{32'h0100_0000, 32'h0110_0000, 32'h0120_0000, 32'h0130_0000};
    exp2 = '{32'd0, 32'd5, 32'd10, 32'd5, 32'd0, 32'd5, 32'd10, 32'd5, 32'd0};

    // reset state
    cyc();
    chk_en = 1'b1;
    cyc();
    check("rst_delta", delta, 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_idx", 32'(idx), 32'h0);
    rst = 1'b0;
    cyc();

    // one-shot ramp N=3 D=1
    launch(1'b0, 32'h0100_0000, 32'h0010_0000, 16'd3, 16'd1);
    for (int i = 0; i < 8; i++) begin
      check("ramp_delta", delta, exp1[i >> 1]);
      check("ramp_idx", 32'(idx), 32'(i >> 1));
      check("ramp_valid", 32'(valid), 32'h1);
      cyc();
    end
    check("ramp_done", 32'(done), 32'h1);
    check("ramp_valid_fall", 32'(valid), 32'h0);
    cyc();
    check("ramp_done_once", 32'(done), 32'h0);

    // triangle N=2 D=0 then abort
    launch(1'b1, 32'd0, 32'd5, 16'd2, 16'd0);
    for (int i = 0; i < 9; i++) begin
      check("tri_delta", delta, exp2[i]);
      check("tri_no_done", 32'(done), 32'h0);
      cyc();
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort_valid", 32'(valid), 32'h0);
    check("abort_delta", delta, 32'h0);
    check("abort_done", 32'(done), 32'h0);
    cyc();

    // wrap-around
    launch(1'b0, 32'h7FFF_FFF0, 32'h20, 16'd1, 16'd0);
    check("wrap_d0", delta, 32'h7FFF_FFF0);
    cyc();
    check("wrap_d1", delta, 32'h8000_0010);
    cyc();
    check("wrap_done", 32'(done), 32'h1);
    cyc();

    // hold 5 cycles during second dwell of the ramp
    n011 = 0;
    done_at = -1;
    launch(1'b0, 32'h0100_0000, 32'h0010_0000, 16'd3, 16'd1);
    for (int s = 0; s < 20; s++) begin
      if (s == 2) hold = 1'b1;
      if (s == 7) hold = 1'b0;
      if (valid && delta == 32'h0110_0000) n011++;
      if (done && done_at < 0) done_at = s;
      cyc();
    end
    check("hold_dwell_len", 32'(n011), 32'd7);
    check("hold_done_at", 32'(done_at), 32'd13);

    // abort together with hold
    launch(1'b0, 32'h0100_0000, 32'h0010_0000, 16'd3, 16'd1);
    cyc();
    hold = 1'b1; abort = 1'b1;
    cyc();
    hold = 1'b0; abort = 1'b0;
    check("abort_hold_valid", 32'(valid), 32'h0);
    check("abort_hold_busy", 32'(busy), 32'h0);
    cyc();

    // N=0 D=0 one-shot
    launch(1'b0, 32'h1234, 32'd7, 16'd0, 16'd0);
    check("n0_valid", 32'(valid), 32'h1);
    check("n0_delta", delta, 32'h1234);
    cyc();
    check("n0_done", 32'(done), 32'h1);
    check("n0_valid_fall", 32'(valid), 32'h0);
    cyc();

    // start with abort in idle
    abort = 1'b1;
    launch(1'b0, 32'h99, 32'd1, 16'd2, 16'd0);
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'h0);
    check("start_abort_valid", 32'(valid), 32'h0);
    cyc();

    // start while busy ignored
    launch(1'b0, 32'd100, 32'd10, 16'd2, 16'd3);
    cyc();
    cyc();
    mode = 1'b1; f_start = 32'd999; f_step = 32'd1; num_steps = 16'd0; dwell = 16'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    check("busy_start_delta", delta, 32'd110);
    check("busy_start_idx", 32'(idx), 32'd1);
    done_at = -1;
    for (int s = 5; s < 20; s++) begin
      if (done && done_at < 0) done_at = s;
      cyc();
    end
    check("busy_start_done_at", 32'(done_at), 32'd12);

    // reset mid-sweep
    launch(1'b1, 32'h55, 32'd3, 16'd3, 16'd1);
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_delta", delta, 32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_idx", 32'(idx), 32'h0);
    cyc();

    // randomized traffic checked by the model
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 59) == 0);
      hold      = ($urandom_range(0, 5) == 0);
      mode      = 1'($urandom_range(0, 1));
      f_start   = $urandom;
      f_step    = $urandom;
      num_steps = 16'($urandom_range(0, 4));
      dwell     = 16'($urandom_range(0, 3));
      cyc();
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
